// File: rtl/crcn_pkg.sv
// crcn_pkg: shared types and CRC helpers for the crcn checker.
// MSB-first, non-reflected remainder arithmetic up to 32 bits.
package crcn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } crcn_state_e;

  localparam int unsigned CRC_MAX_W = 32;

  function automatic bit crc_width_legal(
    input int unsigned w
  );
    return (w == 8) || (w == 16) || (w == 32);
  endfunction

  // Bitwise form of the table step; unrolls to a pure XOR tree.
  function automatic logic [31:0] crc_byte_step(
    input logic [31:0] crc,
    input logic [7:0]  data_byte,
    input logic [31:0] poly,
    input int unsigned width
  );
    logic [31:0] c;
    logic [31:0] top;
    logic [31:0] mask;
    mask = (width == 32) ? 32'hFFFF_FFFF
                         : ((32'd1 << width) - 32'd1);
    top  = 32'd1 << (width - 1);
    c    = crc ^ ({24'd0, data_byte} << (width - 8));
    for (int b = 0; b < 8; b++) begin
      if ((c & top) != 32'd0) begin
        c = (c << 1) ^ poly;
      end else begin
        c = c << 1;
      end
    end
    return c & mask;
  endfunction

endpackage

// File: rtl/crcn_beat_fold.sv
// crcn_beat_fold: folds one beat of bytes into the remainder.
// Purely combinational; byte 0 first, masked bytes pass through.
module crcn_beat_fold
  import crcn_pkg::*;
#(
  parameter int CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(8'h07),
  parameter int DATA_BYTES = 1
) (
  input  logic [CRC_WIDTH-1:0]    seed,
  input  logic [8*DATA_BYTES-1:0] data,
  input  logic [DATA_BYTES-1:0]   keep,
  input  logic                    last,
  output logic [CRC_WIDTH-1:0]    crc_next,
  output logic                    keep_err
);

  logic [CRC_WIDTH-1:0] c;
  logic                 keep_ok;

  always_comb begin
    c = seed;
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (keep[k]) begin
        c = CRC_WIDTH'(crc_byte_step(
          32'(c), data[8*k +: 8],
          32'(POLY), CRC_WIDTH));
      end
    end
    crc_next = c;
  end

  // Contiguous from bit 0: keep+1 clears every set bit.
  assign keep_ok =
    (keep != '0) &&
    ((keep & (keep + DATA_BYTES'(1))) == '0);

  assign keep_err = !keep_ok || (!last && !(&keep));

endmodule

// File: rtl/crcn_checker_sva.sv
// crcn_checker_sva: protocol properties bound into crcn_checker.
// Covers done latency, match/done, hold and reset value.
module crcn_checker_sva #(
  parameter int CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] INIT = CRC_WIDTH'(8'h0D)
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 i_clear,
  input logic                 i_valid,
  input logic                 i_last,
  input logic                 o_done,
  input logic                 o_match,
  input logic [CRC_WIDTH-1:0] o_crc
);

  a_done_lat: assert property (
    @(posedge clk) disable iff (!reset)
    (i_valid && i_last && !i_clear) |=> o_done);

  a_match_done: assert property (
    @(posedge clk) disable iff (!reset)
    o_match |-> o_done);

  a_crc_hold: assert property (
    @(posedge clk) disable iff (!reset)
    (!i_valid && !i_clear) |=> $stable(o_crc));

  a_reset_init: assert property (
    @(posedge clk)
    $rose(reset) |-> (o_crc == INIT));

endmodule

bind crcn_checker crcn_checker_sva #(
  .CRC_WIDTH (CRC_WIDTH),
  .INIT      (INIT)
) u_sva (
  .clk     (clk),
  .reset   (reset),
  .i_clear (i_clear),
  .i_valid (i_valid),
  .i_last  (i_last),
  .o_done  (o_done),
  .o_match (o_match),
  .o_crc   (o_crc)
);

// File: rtl/crcn_checker.sv
// crcn_checker: streaming CRC checker with packet FSM.
// Flags a zero residue one cycle after the last beat.
module crcn_checker
  import crcn_pkg::*;
#(
  parameter int CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY = CRC_WIDTH'(8'h07),
  parameter logic [CRC_WIDTH-1:0] INIT = CRC_WIDTH'(8'h0D),
  parameter int DATA_BYTES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_valid,
  input  logic                    i_last,
  input  logic [DATA_BYTES-1:0]   i_keep,
  input  logic [8*DATA_BYTES-1:0] i_data,
  output logic [CRC_WIDTH-1:0]    o_crc,
  output logic                    o_done,
  output logic                    o_match,
  output logic                    o_err
);

  localparam bit WIDTH_OK = crc_width_legal(CRC_WIDTH);

  if (!WIDTH_OK) begin : g_bad_width
    $error("crcn_checker: CRC_WIDTH must be 8, 16 or 32");
  end

  crcn_state_e          state_q;
  crcn_state_e          state_d;
  logic [CRC_WIDTH-1:0] crc_q;
  logic [CRC_WIDTH-1:0] crc_d;
  logic [CRC_WIDTH-1:0] seed;
  logic [CRC_WIDTH-1:0] fold_crc;
  logic                 fold_err;
  logic                 match_q;
  logic                 match_d;
  logic                 err_q;
  logic                 err_d;
  logic                 accept;

  // Only a packet in flight carries its remainder forward.
  assign seed = (state_q == BUSY) ? crc_q : INIT;

  crcn_beat_fold #(
    .CRC_WIDTH  (CRC_WIDTH),
    .POLY       (POLY),
    .DATA_BYTES (DATA_BYTES)
  ) u_fold (
    .seed     (seed),
    .data     (i_data),
    .keep     (i_keep),
    .last     (i_last),
    .crc_next (fold_crc),
    .keep_err (fold_err)
  );

  assign accept = i_valid && !i_clear;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    match_d = match_q;
    err_d   = err_q;
    unique case (1'b1)
      i_clear: begin
        state_d = IDLE;
        crc_d   = INIT;
        match_d = 1'b0;
        err_d   = 1'b0;
      end
      accept: begin
        crc_d   = fold_crc;
        state_d = i_last ? DONE : BUSY;
        match_d = i_last && (fold_crc == '0);
        err_d   = fold_err ||
                  (err_q && (state_q == BUSY));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      crc_q   <= INIT;
      match_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  assign o_crc   = crc_q;
  assign o_done  = (state_q == DONE);
  assign o_match = match_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_crcn_checker.sv
// tb_crcn_checker: directed checks of crcn_checker.
// Four configurations share two byte-wide and word-wide streams.
module tb_crcn_checker;

  logic clk;
  logic reset;

  logic       a_clear;
  logic       a_valid;
  logic       a_last;
  logic [0:0] a_keep;
  logic [7:0] a_data;

  logic        b_clear;
  logic        b_valid;
  logic        b_last;
  logic [3:0]  b_keep;
  logic [31:0] b_data;

  logic [7:0]  c8_crc;
  logic        c8_done, c8_match, c8_err;
  logic [7:0]  d8_crc;
  logic        d8_done, d8_match, d8_err;
  logic [15:0] c16_crc;
  logic        c16_done, c16_match, c16_err;
  logic [31:0] c32_crc;
  logic        c32_done, c32_match, c32_err;

  int passed;
  int total;

  crcn_checker #(
    .CRC_WIDTH (8), .POLY (8'h07),
    .INIT (8'h00), .DATA_BYTES (1)
  ) u8 (
    .clk (clk), .reset (reset),
    .i_clear (a_clear), .i_valid (a_valid),
    .i_last (a_last), .i_keep (a_keep),
    .i_data (a_data), .o_crc (c8_crc),
    .o_done (c8_done), .o_match (c8_match),
    .o_err (c8_err)
  );

  crcn_checker #(
    .CRC_WIDTH (8), .POLY (8'h07),
    .INIT (8'h0D), .DATA_BYTES (1)
  ) u8d (
    .clk (clk), .reset (reset),
    .i_clear (a_clear), .i_valid (a_valid),
    .i_last (a_last), .i_keep (a_keep),
    .i_data (a_data), .o_crc (d8_crc),
    .o_done (d8_done), .o_match (d8_match),
    .o_err (d8_err)
  );

  crcn_checker #(
    .CRC_WIDTH (16), .POLY (16'h1021),
    .INIT (16'hFFFF), .DATA_BYTES (4)
  ) u16 (
    .clk (clk), .reset (reset),
    .i_clear (b_clear), .i_valid (b_valid),
    .i_last (b_last), .i_keep (b_keep),
    .i_data (b_data), .o_crc (c16_crc),
    .o_done (c16_done), .o_match (c16_match),
    .o_err (c16_err)
  );

  crcn_checker #(
    .CRC_WIDTH (32), .POLY (32'h04C11DB7),
    .INIT (32'hFFFFFFFF), .DATA_BYTES (4)
  ) u32 (
    .clk (clk), .reset (reset),
    .i_clear (b_clear), .i_valid (b_valid),
    .i_last (b_last), .i_keep (b_keep),
    .i_data (b_data), .o_crc (c32_crc),
    .o_done (c32_done), .o_match (c32_match),
    .o_err (c32_err)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h",
                tag, obs, exp);
  endtask

  task automatic beat_a(
    input logic       v,
    input logic       l,
    input logic       clr,
    input logic [7:0] d
  );
    @(negedge clk);
    a_valid = v;
    a_last  = l;
    a_clear = clr;
    a_data  = d;
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_clear = 1'b0;
  endtask

  task automatic beat_b(
    input logic        v,
    input logic        l,
    input logic        clr,
    input logic [3:0]  k,
    input logic [31:0] d
  );
    @(negedge clk);
    b_valid = v;
    b_last  = l;
    b_clear = clr;
    b_keep  = k;
    b_data  = d;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    b_last  = 1'b0;
    b_clear = 1'b0;
    b_keep  = 4'hF;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic msg_b();
    beat_b(1, 0, 0, 4'hF, 32'h34333231);
    beat_b(1, 0, 0, 4'hF, 32'h38373635);
  endtask

  initial begin
    clk     = 1'b0;
    reset   = 1'b0;
    a_clear = 1'b0;
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_keep  = 1'b1;
    a_data  = 8'h00;
    b_clear = 1'b0;
    b_valid = 1'b0;
    b_last  = 1'b0;
    b_keep  = 4'hF;
    b_data  = 32'h0;
    passed  = 0;
    total   = 0;

    idle(3);
    chk("rst_crc", 32'(d8_crc), 32'h0D);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("hold_crc", 32'(d8_crc), 32'h0D);
      chk("hold_done", 32'(d8_done), 32'h0);
      chk("hold_match", 32'(d8_match), 32'h0);
    end
    chk("rst_c16", 32'(c16_crc), 32'hFFFF);
    chk("rst_c32", c32_crc, 32'hFFFFFFFF);

    for (int i = 0; i < 9; i++) begin
      beat_a(1, i == 8, 0, 8'h31 + 8'(i));
      if (i == 7) begin
        chk("c8_pre_done", 32'(c8_done), 32'h0);
      end
    end
    chk("c8_check", 32'(c8_crc), 32'hF4);
    chk("c8_done", 32'(c8_done), 32'h1);
    chk("c8_nomatch", 32'(c8_match), 32'h0);
    chk("c8_err", 32'(c8_err), 32'h0);
    chk("d8_err", 32'(d8_err), 32'h0);
    idle(2);
    chk("c8_done_hold", 32'(c8_crc), 32'hF4);
    chk("c8_done_stay", 32'(c8_done), 32'h1);

    beat_a(1, 0, 0, 8'h31);
    chk("c8_reseed", 32'(c8_crc), 32'h97);
    chk("c8_done_fall", 32'(c8_done), 32'h0);
    idle(3);
    chk("c8_gap", 32'(c8_crc), 32'h97);
    for (int i = 1; i < 9; i++) begin
      beat_a(1, 0, 0, 8'h31 + 8'(i));
    end
    chk("c8_pre_match", 32'(c8_match), 32'h0);
    beat_a(1, 1, 0, 8'hF4);
    chk("c8_residue", 32'(c8_crc), 32'h00);
    chk("c8_match", 32'(c8_match), 32'h1);
    chk("c8_match_done", 32'(c8_done), 32'h1);

    beat_a(1, 1, 1, 8'h55);
    chk("clr_d8_crc", 32'(d8_crc), 32'h0D);
    chk("clr_d8_done", 32'(d8_done), 32'h0);
    chk("clr_d8_match", 32'(d8_match), 32'h0);
    chk("clr_c8_match", 32'(c8_match), 32'h0);
    chk("clr_c8_done", 32'(c8_done), 32'h0);
    idle(1);
    chk("clr_d8_hold", 32'(d8_crc), 32'h0D);

    beat_a(1, 1, 0, 8'h31);
    chk("c8_single", 32'(c8_crc), 32'h97);
    chk("c8_single_done", 32'(c8_done), 32'h1);

    msg_b();
    chk("c16_pre_done", 32'(c16_done), 32'h0);
    beat_b(1, 1, 0, 4'h1, 32'h00000039);
    chk("c16_check", 32'(c16_crc), 32'h29B1);
    chk("c32_check", c32_crc, 32'h0376E6E7);
    chk("c16_done", 32'(c16_done), 32'h1);
    chk("c16_err", 32'(c16_err), 32'h0);
    chk("c32_nomatch", 32'(c32_match), 32'h0);

    msg_b();
    chk("c32_done_fall", 32'(c32_done), 32'h0);
    beat_b(1, 1, 0, 4'h7, 32'h00B12939);
    chk("c16_residue", 32'(c16_crc), 32'h0000);
    chk("c16_match", 32'(c16_match), 32'h1);
    chk("c32_err_ok", 32'(c32_err), 32'h0);

    msg_b();
    beat_b(1, 1, 0, 4'h1, 32'h00000039);
    chk("b2b_c16", 32'(c16_crc), 32'h29B1);
    chk("b2b_c32", c32_crc, 32'h0376E6E7);
    chk("b2b_c16_match", 32'(c16_match), 32'h0);

    beat_b(1, 1, 0, 4'h5, 32'h34333231);
    chk("kerr_c32", 32'(c32_err), 32'h1);
    chk("kerr_done", 32'(c32_done), 32'h1);
    chk("kerr_c16", 32'(c16_err), 32'h1);
    beat_b(1, 0, 0, 4'hF, 32'h34333231);
    chk("kerr_restart", 32'(c32_err), 32'h0);
    chk("kerr_rs_done", 32'(c32_done), 32'h0);
    beat_b(1, 0, 0, 4'h3, 32'h38373635);
    chk("kerr_nonlast", 32'(c32_err), 32'h1);
    beat_b(1, 1, 0, 4'h1, 32'h00000039);
    chk("kerr_sticky", 32'(c32_err), 32'h1);
    chk("kerr_st_done", 32'(c32_done), 32'h1);

    beat_b(0, 0, 1, 4'hF, 32'h0);
    chk("clr_c16_crc", 32'(c16_crc), 32'hFFFF);
    chk("clr_c32_err", 32'(c32_err), 32'h0);
    chk("clr_c16_done", 32'(c16_done), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
